// File: rtl/vlan_lookup_forwarder_pkg.sv
// Shared widths, field offsets, FSM state type and beat struct for the VLAN lookup forwarder.
package pkt_fwd_pkg;

  localparam int unsigned AXIS_DATA_SIZE = 32;
  localparam int unsigned USER_SIZE      = 16;
  localparam int unsigned TBL_ADDR_SIZE  = 15;
  localparam int unsigned DATA_SIZE      = 32;
  localparam int unsigned DEST_SIZE      = 5;

  localparam int unsigned VLAN_MSB      = 15;
  localparam int unsigned VLAN_LSB      = 4;
  localparam int unsigned PORT_MSB      = 2;
  localparam int unsigned ENT_VALID_BIT = 31;
  localparam int unsigned ENT_DEST_MSB  = 4;

  typedef enum logic [1:0] {IDLE, LOOKUP, FWD, DROP} fwd_state_t;

  typedef struct packed {
    logic [AXIS_DATA_SIZE-1:0] tdata;
    logic [USER_SIZE-1:0]      tuser;
    logic                      tlast;
    logic [DEST_SIZE-1:0]      tdest;
  } axis_beat_t;

  // Table index is {port_id, vlan}.
  function automatic logic [TBL_ADDR_SIZE-1:0] tbl_index(input logic [USER_SIZE-1:0] tuser);
    return {tuser[PORT_MSB:0], tuser[VLAN_MSB:VLAN_LSB]};
  endfunction

endpackage

// File: rtl/vlan_lookup_forwarder_if.sv
// AXI-Stream bundle used for both the ingress and egress sides of the forwarder.
interface vlan_lookup_forwarder_if;
  import pkt_fwd_pkg::*;

  logic                      tvalid;
  logic                      tready;
  logic [AXIS_DATA_SIZE-1:0] tdata;
  logic [USER_SIZE-1:0]      tuser;
  logic                      tlast;
  logic [DEST_SIZE-1:0]      tdest;

  modport master (output tvalid, tdata, tuser, tlast, tdest, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, tdest, output tready);

endinterface

// File: rtl/vlan_lookup_forwarder_skid.sv
// Two-entry registered AXIS buffer; in_ready_o depends only on the occupancy register.
module axis_skid_buf
  import pkt_fwd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  axis_beat_t in_beat_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output axis_beat_t out_beat_o
);

  axis_beat_t mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_beat_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_beat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vlan_lookup_forwarder.sv
// Looks up {port_id, vlan} of each ingress packet and forwards it with an egress port or drops it.
module vlan_lookup_forwarder
  import pkt_fwd_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  vlan_lookup_forwarder_if.slave   s_axis,
  vlan_lookup_forwarder_if.master  m_axis,
  output logic                     tbl_rd_en,
  output logic [TBL_ADDR_SIZE-1:0] tbl_rd_addr,
  input  logic [DATA_SIZE-1:0]     tbl_rd_data,
  output logic [31:0]              fwd_pkt_cnt,
  output logic [31:0]              drop_pkt_cnt
);

  fwd_state_t           state_q;
  logic [DEST_SIZE-1:0] dest_q;
  logic [31:0]          fwd_cnt_q, drop_cnt_q;
  logic                 skid_ready, skid_in_valid, s_hs, pkt_end;
  axis_beat_t           in_beat, out_beat;

  assign s_axis.tready = (state_q == DROP) || ((state_q == FWD) && skid_ready);
  assign s_hs          = s_axis.tvalid & s_axis.tready;
  assign pkt_end       = s_hs & s_axis.tlast;
  assign skid_in_valid = (state_q == FWD) && s_axis.tvalid;

  // Only the first beat sees IDLE, so only it issues a table read.
  assign tbl_rd_en   = (state_q == IDLE) && s_axis.tvalid;
  assign tbl_rd_addr = tbl_index(s_axis.tuser);

  assign in_beat = '{tdata: s_axis.tdata, tuser: s_axis.tuser, tlast: s_axis.tlast, tdest: dest_q};

  assign fwd_pkt_cnt  = fwd_cnt_q;
  assign drop_pkt_cnt = drop_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{tbl_rd_data[ENT_VALID_BIT-1:ENT_DEST_MSB+1], s_axis.tdest};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dest_q     <= '0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (s_axis.tvalid) state_q <= LOOKUP;
        LOOKUP: begin
          if (tbl_rd_data[ENT_VALID_BIT]) begin
            dest_q  <= tbl_rd_data[ENT_DEST_MSB:0];
            state_q <= FWD;
          end else begin
            state_q <= DROP;
          end
        end
        FWD: if (pkt_end) begin
          if (fwd_cnt_q != '1) fwd_cnt_q <= fwd_cnt_q + 32'd1;
          state_q <= IDLE;
        end
        DROP: if (pkt_end) begin
          if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 32'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axis_skid_buf u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (skid_in_valid),
    .in_ready_o  (skid_ready),
    .in_beat_i   (in_beat),
    .out_valid_o (m_axis.tvalid),
    .out_ready_i (m_axis.tready),
    .out_beat_o  (out_beat)
  );

  assign m_axis.tdata = out_beat.tdata;
  assign m_axis.tuser = out_beat.tuser;
  assign m_axis.tlast = out_beat.tlast;
  assign m_axis.tdest = out_beat.tdest;

endmodule

// File: doc/vlan_lookup_forwarder.md
Name: vlan_lookup_forwarder

Overview:
Downstream stage of the register/connection-config block. Consumes ingress AXI-Stream packets and forms the lookup index {port_id, vlan} from the first-beat tuser. Reads the 32K-entry connection config table through a 1-cycle-latency read port, then either forwards the whole packet with an egress port on m_tdest or drops it. Keeps saturating forward and drop packet counters for register readback.

Parameters:
AXIS_DATA_SIZE, 32, tdata width
USER_SIZE, 16, tuser width; vlan = tuser[15:4], port_id = tuser[2:0]
TBL_ADDR_SIZE, 15, table index width = 3 (port_id) + 12 (vlan)
DATA_SIZE, 32, config entry width; [31] valid, [4:0] egress port
DEST_SIZE, 5, m_tdest width (32 output ports)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
s_tvalid  in  1  ingress beat valid
s_tready  out  1  ingress ready
s_tdata  in  AXIS_DATA_SIZE  ingress data
s_tuser  in  USER_SIZE  ingress sideband; only first beat is used
s_tlast  in  1  last beat of packet
tbl_rd_en  out  1  table read strobe
tbl_rd_addr  out  TBL_ADDR_SIZE  {port_id, vlan}
tbl_rd_data  in  DATA_SIZE  entry, valid the cycle after tbl_rd_en
m_tvalid  out  1  egress valid
m_tready  in  1  egress ready
m_tdata  out  AXIS_DATA_SIZE  egress data
m_tuser  out  USER_SIZE  egress sideband, passed through per beat
m_tlast  out  1  egress last
m_tdest  out  DEST_SIZE  egress port, constant for the whole packet
fwd_pkt_cnt  out  32  forwarded packets, saturating
drop_pkt_cnt  out  32  dropped packets, saturating

Behaviour:
- Reset: state IDLE, s_tready=0, tbl_rd_en=0, m_tvalid=0, m_tlast=0, m_tdest=0, both counters 0, skid buffer emptied. Reset mid-packet abandons the packet with no counter update. The next s_tvalid after reset is treated as a packet start.
- IDLE: s_tready=0. When s_tvalid=1, drive tbl_rd_en=1 and tbl_rd_addr={s_tuser[2:0], s_tuser[15:4]} combinationally. Go to LOOKUP.
- LOOKUP: s_tready=0. Sample tbl_rd_data.
  - If [31]=1: latch dest=[4:0] and go to FWD.
  - Else go to DROP.
  - s_tdata/s_tuser must be held by upstream (AXIS rule), so no header capture register is needed.
- FWD: s_tready = skid-buffer ready. Each s handshake pushes {tdata, tuser, tlast, dest} into the skid buffer. On handshake with s_tlast=1, increment fwd_pkt_cnt and go to IDLE.
- DROP: s_tready=1 and beats are discarded. On handshake with s_tlast=1, increment drop_pkt_cnt and go to IDLE.
- Single-beat packets (tlast on first beat) are legal in both FWD and DROP.
- Latency: first s_tvalid at cycle N gives tbl_rd_en at N, decision at N+1, first s handshake at N+2, m_tvalid at N+3 (with m_tready=1).
- Throughput: 1 beat/cycle inside a packet; 2 bubble cycles between packets (IDLE, LOOKUP).
- Egress AXIS: m_tvalid never drops without a handshake, and m_* stay stable while m_tvalid=1 and m_tready=0.
- Skid buffer: 2 entries, so s_tready depends only on registered state, never combinationally on m_tready.
- Counters: saturate at 32'hFFFF_FFFF, with no wrap.
- tuser changes after the first beat do not affect m_tdest.
- Only the first beat of each packet issues a table read.
- No AXIS backpressure during DROP, even when m_tready=0.

Decomposition:
- Package pkt_fwd_pkg holds:
  - tuser field offsets (VLAN_MSB=15, VLAN_LSB=4, PORT_MSB=2)
  - entry field offsets (ENT_VALID_BIT=31, ENT_DEST_MSB=4)
  - fwd_state_t enum {IDLE, LOOKUP, FWD, DROP}
  - function tbl_index(tuser) returning {port_id, vlan}
- One sub-module: axis_skid_buf, a 2-entry registered AXIS buffer carrying {tdata, tuser, tlast, tdest}.

Test Plan:
- Entry[{3'd2, 12'd100}]=32'h8000_0007; 4-beat packet with tuser[15:4]=100, tuser[2:0]=2 -> tbl_rd_addr=15'h2064, 4 beats out with m_tdest=7, tlast on beat 4, fwd_pkt_cnt=1, first m_tvalid 3 cycles after s_tvalid.
- Entry[{3'd1, 12'd5}]=32'h0000_0003 (valid=0); 3-beat packet on port 1, vlan 5 -> no m_tvalid, s_tready=1 for 3 cycles after LOOKUP, drop_pkt_cnt=1.
- Forwarded 6-beat packet with m_tready toggling 1,0,0,1 -> all 6 beats in order, no data change while stalled, no loss or duplication.
- Back-to-back single-beat packets, dest 3 then invalid then dest 9 -> out 2 beats with m_tdest 3 then 9; fwd=2, drop=1; 2-cycle gap between s handshakes.
- Assert reset during beat 2 of a forwarded packet, then send a new valid packet -> all outputs at reset values the next cycle, counters 0, new packet forwarded correctly.
- Preload fwd_pkt_cnt near saturation via force, then forward 2 packets -> counter holds at 32'hFFFF_FFFF.
